// File: rtl/geo_pkg.sv
// Shared types and constants for the geofence frame feeder.
package geo_pkg;

    localparam int COORD_W   = 10;
    localparam int FRAME_LEN = 7;
    localparam int IDX_W     = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        PARK,
        STREAM,
        WAIT
    } feeder_state_t;

endpackage

// File: rtl/geo_frame_bank.sv
// Two-bank point store: one bank fills while the other is replayed; each bank
// has a full flag that only the read side's free pulse can clear.
module geo_frame_bank
    import geo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid_i,
    input  point_t           wr_data_i,
    output logic             wr_ready_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output point_t           rd_data_o,
    output logic             rd_full_o,
    input  logic             free_i
);

    point_t           mem_q [2][FRAME_LEN];
    logic [1:0]       full_q, full_d;
    logic             wrBank_q, rdBank_q;
    logic [IDX_W-1:0] wrIdx_q, wrIdx_d;
    logic             wrFire;
    logic             wrLast;

    assign wr_ready_o = !full_q[wrBank_q];
    assign wrFire     = wr_valid_i && wr_ready_o;
    assign wrLast     = wrFire && (wrIdx_q == LAST_IDX);
    assign rd_full_o  = full_q[rdBank_q];
    assign rd_data_o  = mem_q[rdBank_q][rd_idx_i];

    // Filling one bank and freeing the other can coincide; both updates apply.
    always_comb begin
        full_d  = full_q;
        wrIdx_d = wrIdx_q;
        if (wrFire) begin
            if (wrLast) begin
                full_d[wrBank_q] = 1'b1;
                wrIdx_d          = '0;
            end else begin
                wrIdx_d = wrIdx_q + 3'd1;
            end
        end
        if (free_i) begin
            full_d[rdBank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            wrIdx_q  <= '0;
            wrBank_q <= 1'b0;
            rdBank_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            wrIdx_q <= wrIdx_d;
            if (wrLast) begin
                wrBank_q <= ~wrBank_q;
            end
            if (free_i) begin
                rdBank_q <= ~rdBank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem_q[wrBank_q][wrIdx_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/geo_frame_feeder.sv
// Frame feeder for the geofence engine: buffers 7-point frames, replays them to
// the engine and captures its verdict. GEO_FEEDER_TIMEOUT_EN adds a result watchdog.
module geo_frame_feeder
    import geo_pkg::*;
#(
    parameter int ID_W = 8
`ifdef GEO_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               fence_rst,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               fence_valid,
    input  logic               fence_inside,
    output logic               res_valid,
    output logic               res_inside,
    output logic [ID_W-1:0]    res_id
`ifdef GEO_FEEDER_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    feeder_state_t    state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    point_t           xy_q, xy_d;
    logic             fenceRst_q;
    logic             resValid_q, resValid_d;
    logic             resInside_q, resInside_d;
    logic [ID_W-1:0]  resId_q, resId_d;
    logic [ID_W-1:0]  frameId_q, frameId_d;
    logic             free;
    logic [IDX_W-1:0] rdIdx;
    point_t           rdData;
    logic             rdFull;
    point_t           inPoint;

`ifdef GEO_FEEDER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             timeoutErr_q, timeoutErr_d;
`endif

    assign inPoint = '{x: in_x, y: in_y};

    geo_frame_bank u_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (in_valid),
        .wr_data_i  (inPoint),
        .wr_ready_o (in_ready),
        .rd_idx_i   (rdIdx),
        .rd_data_o  (rdData),
        .rd_full_o  (rdFull),
        .free_i     (free)
    );

    // X/Y are registered, so the bank is read one word ahead of what is on the outputs.
    assign rdIdx = (state_q == STREAM && k_q != LAST_IDX) ? k_q + 3'd1 : '0;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        xy_d        = xy_q;
        resValid_d  = 1'b0;
        resInside_d = resInside_q;
        resId_d     = resId_q;
        frameId_d   = frameId_q;
        free        = 1'b0;
`ifdef GEO_FEEDER_TIMEOUT_EN
        waitCnt_d    = '0;
        timeoutErr_d = timeoutErr_q;
`endif
        unique case (state_q)
            PARK: begin
                if (rdFull) begin
                    state_d = STREAM;
                    k_d     = '0;
                    xy_d    = rdData;
                end
            end
            STREAM: begin
                if (k_q == LAST_IDX) begin
                    state_d = WAIT;
                    k_d     = '0;
                end else begin
                    k_d  = k_q + 3'd1;
                    xy_d = rdData;
                end
            end
            WAIT: begin
                if (fence_valid) begin
                    resValid_d  = 1'b1;
                    resInside_d = fence_inside;
                    resId_d     = frameId_q;
                    frameId_d   = frameId_q + ID_W'(1);
                    free        = 1'b1;
                    state_d     = PARK;
                end
`ifdef GEO_FEEDER_TIMEOUT_EN
                else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeoutErr_d = 1'b1;
                    frameId_d    = frameId_q + ID_W'(1);
                    free         = 1'b1;
                    state_d      = PARK;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = PARK;
            end
        endcase
    end

    // fence_rst follows the next state so the engine is held in every PARK cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PARK;
            k_q         <= '0;
            xy_q        <= '0;
            fenceRst_q  <= 1'b1;
            resValid_q  <= 1'b0;
            resInside_q <= 1'b0;
            resId_q     <= '0;
            frameId_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            xy_q        <= xy_d;
            fenceRst_q  <= (state_d == PARK);
            resValid_q  <= resValid_d;
            resInside_q <= resInside_d;
            resId_q     <= resId_d;
            frameId_q   <= frameId_d;
        end
    end

`ifdef GEO_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            waitCnt_q    <= waitCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign timeout_err = timeoutErr_q;
`endif

    assign fence_rst  = fenceRst_q;
    assign X          = xy_q.x;
    assign Y          = xy_q.y;
    assign res_valid  = resValid_q;
    assign res_inside = resInside_q;
    assign res_id     = resId_q;

endmodule

// File: tb/tb_geo_frame_feeder.sv
// Randomized bench for geo_frame_feeder against a frame-timeline reference model.
// Define GEO_FEEDER_TIMEOUT_EN to also exercise the result watchdog.
module tb_geo_frame_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic       fence_valid = 1'b0;
    logic       fence_inside = 1'b0;
    logic       in_ready, fence_rst, res_valid, res_inside;
    logic [9:0] X, Y;
    logic [7:0] res_id;
`ifdef GEO_FEEDER_TIMEOUT_EN
    logic       timeout_err;
    localparam int TIMEOUT_CYC = 64;
`endif

    always #5 clk = ~clk;

    geo_frame_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .fence_rst    (fence_rst),
        .X            (X),
        .Y            (Y),
        .fence_valid  (fence_valid),
        .fence_inside (fence_inside),
        .res_valid    (res_valid),
        .res_inside   (res_inside),
        .res_id       (res_id)
`ifdef GEO_FEEDER_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    typedef struct packed {
        logic [6:0][9:0] xs;
        logic [6:0][9:0] ys;
        logic [31:0]     ready;
    } frame_t;

    // Model: full frames in arrival order; the head is the one the engine owns.
    frame_t          frames[$];
    logic [6:0][9:0] curXs, curYs;
    int              curCnt = 0;
    int              cyc = 0;
    int              startCyc = -1;
    int              lastFree = 0;
    int              nextId = 0;
    int              respDelay = 0;
    int              forceInside = -1;
    bit              spurEn = 1'b0;
    bit              noResp = 1'b0;
    logic [9:0]      expX = '0, expY = '0;
    logic            expResValid = 1'b0, expResInside = 1'b0, expTimeoutErr = 1'b0;
    logic [7:0]      expResId = '0;
    int              errors = 0;
    int              checks = 0;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic finishFrame();
        void'(frames.pop_front());
        nextId++;
        lastFree  = cyc;
        startCyc  = -1;
        respDelay = $urandom_range(0, 4);
    endtask

    // One clock: drive the engine stand-in, advance the model, then compare outputs.
    task automatic tick();
        logic   acc, fv, fi, rstNow, waitingNow;
        int     waitAge, k;
        frame_t f;
        waitingNow = (startCyc >= 0) && (cyc >= startCyc + 7);
        waitAge    = waitingNow ? (cyc - startCyc - 7) : 0;
        if (reset)
            fence_valid = 1'b0;
        else if (waitingNow)
            fence_valid = !noResp && (waitAge >= respDelay);
        else
            fence_valid = spurEn && ($urandom_range(0, 3) == 0);
        fence_inside = (forceInside >= 0) ? forceInside[0] : 1'($urandom_range(0, 1));
        rstNow = reset;
        acc    = in_valid && (frames.size() < 2);
        fv     = fence_valid;
        fi     = fence_inside;
        @(posedge clk);
        cyc++;
        expResValid = 1'b0;
        if (rstNow) begin
            frames.delete();
            curCnt        = 0;
            startCyc      = -1;
            lastFree      = cyc;
            nextId        = 0;
            expX          = '0;
            expY          = '0;
            expResInside  = 1'b0;
            expResId      = '0;
            expTimeoutErr = 1'b0;
        end else begin
            if (waitingNow && fv) begin
                expResValid  = 1'b1;
                expResInside = fi;
                expResId     = 8'(nextId);
                finishFrame();
            end
`ifdef GEO_FEEDER_TIMEOUT_EN
            else if (waitingNow && waitAge == TIMEOUT_CYC - 1) begin
                expTimeoutErr = 1'b1;
                finishFrame();
            end
`endif
            if (acc) begin
                curXs[curCnt] = in_x;
                curYs[curCnt] = in_y;
                curCnt++;
                if (curCnt == 7) begin
                    f.xs    = curXs;
                    f.ys    = curYs;
                    f.ready = 32'(cyc);
                    frames.push_back(f);
                    curCnt = 0;
                end
            end
        end
        if (startCyc < 0 && frames.size() > 0) begin
            f        = frames[0];
            startCyc = maxInt(int'(f.ready), lastFree) + 1;
        end
        if (startCyc >= 0 && cyc >= startCyc) begin
            f    = frames[0];
            k    = (cyc - startCyc > 6) ? 6 : (cyc - startCyc);
            expX = f.xs[k];
            expY = f.ys[k];
        end
        #1;
        checkOutput("in_ready", in_ready, frames.size() < 2);
        checkOutput("fence_rst", fence_rst, !(startCyc >= 0 && cyc >= startCyc));
        checkOutput("X", X, expX);
        checkOutput("Y", Y, expY);
        checkOutput("res_valid", res_valid, expResValid);
        checkOutput("res_inside", res_inside, expResInside);
        checkOutput("res_id", res_id, expResId);
`ifdef GEO_FEEDER_TIMEOUT_EN
        checkOutput("timeout_err", timeout_err, expTimeoutErr);
`endif
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pushPoint(input logic [9:0] px, input logic [9:0] py, input int gap);
        logic accepted;
        int   budget;
        accepted = 1'b0;
        budget   = 0;
        in_valid = 1'b1;
        in_x     = px;
        in_y     = py;
        while (!accepted && budget < 400) begin
            accepted = (frames.size() < 2);
            tick();
            budget++;
        end
        checkOutput("accept", accepted, 1);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    // gapMode: 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
    task automatic applyStimulus(input int nFrames, input int gapMode);
        int gap;
        for (int fr = 0; fr < nFrames; fr++) begin
            for (int p = 0; p < 7; p++) begin
                gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : $urandom_range(0, 3);
                pushPoint(10'($urandom), 10'($urandom), gap);
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (frames.size() > 0 && budget < 600) begin
            tick();
            budget++;
        end
        checkOutput("drain", frames.size() == 0, 1);
        tick();
        tick();
    endtask

    initial begin
        int budget;
        applyReset();

        forceInside = 1;
        pushPoint(10'd100, 10'd100, 0);
        pushPoint(10'd0,   10'd0,   0);
        pushPoint(10'd200, 10'd0,   0);
        pushPoint(10'd300, 10'd100, 0);
        pushPoint(10'd200, 10'd200, 0);
        pushPoint(10'd0,   10'd200, 0);
        pushPoint(10'd100, 10'd50,  0);
        drain();
        forceInside = -1;

        applyStimulus(2, 0);
        drain();

        applyStimulus(2, 1);
        drain();

        spurEn = 1'b1;
        applyStimulus(3, 2);
        drain();
        spurEn = 1'b0;

        applyStimulus(1, 0);
        budget = 0;
        while (!(startCyc >= 0 && cyc == startCyc + 3) && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput("reach_k3", (startCyc >= 0 && cyc == startCyc + 3), 1);
        applyReset();
        applyStimulus(1, 2);
        drain();

        spurEn = 1'b1;
        applyStimulus(4, 2);
        drain();
        spurEn = 1'b0;

`ifdef GEO_FEEDER_TIMEOUT_EN
        noResp = 1'b1;
        applyStimulus(1, 0);
        drain();
        noResp = 1'b0;
        applyStimulus(1, 0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
